i2c_target_regfile: RTL and testbench

Parametrised I2C target (slave) with an internal byte-wide register file. It succeeds the fixed-frequency, single-byte slave, with these changes:
- It is oversampled and edge-driven from the bus pins rather than pulse-timed.
- It filters glitches and detects START, repeated START and STOP anywhere in a transfer.
- It matches a configurable 7-bit device address.
- It supports multi-byte burst writes and reads through an auto-incrementing register pointer.

It sits behind the board-level open-drain pad. The pad drives SDA low when `sda_oe`=1.

---
 rtl/i2c_target_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing byte register file.
// Oversampled bus pins are synchronised, glitch-filtered and decoded into edge/START/STOP events.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned FILT_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] ptr
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through the synchroniser and filter
    logic [1:0]    sync1, sync2, filt, filt_q;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {scl, sda_i};
            sync2  <= sync1;
            filt_q <= filt;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == filt[k]) begin
                    fcnt[k] <= '0;
                end else if (fcnt[k] == CW'(FILT_LEN - 1)) begin
                    filt[k] <= sync2[k];
                    fcnt[k] <= '0;
                end else begin
                    fcnt[k] <= fcnt[k] + CW'(1);
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise_c, scl_fall_c, start_c, stop_c;
    assign scl_f      = filt[1];
    assign sda_f      = filt[0];
    assign scl_rise_c = scl_f & ~filt_q[1];
    assign scl_fall_c = ~scl_f & filt_q[1];
    assign start_c    = scl_f & filt_q[1] & ~sda_f & filt_q[0];
    assign stop_c     = scl_f & filt_q[1] & sda_f & ~filt_q[0];

    state_t     state, state_n;
    logic [3:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n, ptr_n, rd_data, ptr_inc;
    logic       rw, rw_n, mack, mack_n, wr_req, wr_req_n;
    logic       sda_oe_n, busy_n, done_n, ack_err_n, load_rd;
    logic [7:0] mem [MEM_DEPTH];

    assign ptr_inc = (ptr == 8'(MEM_DEPTH - 1)) ? 8'd0 : ptr + 8'd1;

    // Next-state and output decode; bus conditions override the per-state behaviour
    always_comb begin
        state_n   = state;
        bcnt_n    = bcnt;
        shreg_n   = shreg;
        rw_n      = rw;
        mack_n    = mack;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = 1'b0;
        wr_req_n  = 1'b0;
        load_rd   = 1'b0;
        case (state)
            ADDR, PTR, WDATA: begin
                if (scl_rise_c) begin
                    shreg_n = {shreg[6:0], sda_f};
                    bcnt_n  = bcnt + 4'd1;
                    if (state == WDATA && bcnt == 4'd7) wr_req_n = 1'b1;
                end else if (scl_fall_c && bcnt == 4'd8) begin
                    bcnt_n = '0;
                    if (state == ADDR) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            state_n  = ADDR_ACK;
                            rw_n     = shreg[0];
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (state == PTR) begin
                        if ({1'b0, shreg} < 9'(MEM_DEPTH)) begin
                            ptr_n    = shreg;
                            sda_oe_n = 1'b1;
                            state_n  = PTR_ACK;
                        end else begin
                            ack_err_n = 1'b1;
                            state_n   = IGNORE;
                        end
                    end else begin
                        ptr_n    = ptr_inc;
                        sda_oe_n = 1'b1;
                        state_n  = WDATA_ACK;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall_c) begin
                    bcnt_n = '0;
                    if (rw) begin
                        load_rd = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = PTR;
                    end
                end
            end
            PTR_ACK, WDATA_ACK: begin
                if (scl_fall_c) begin
                    sda_oe_n = 1'b0;
                    bcnt_n   = '0;
                    state_n  = WDATA;
                end
            end
            RDATA: begin
                if (scl_rise_c) begin
                    bcnt_n = bcnt + 4'd1;
                end else if (scl_fall_c) begin
                    if (bcnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        bcnt_n   = '0;
                        state_n  = RDATA_ACK;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end
            end
            RDATA_ACK: begin
                if (scl_rise_c) begin
                    mack_n = sda_f;
                    bcnt_n = 4'd1;
                end else if (scl_fall_c && bcnt == 4'd1) begin
                    bcnt_n = '0;
                    if (!mack) load_rd = 1'b1;
                    else       state_n = IGNORE;
                end
            end
            default: sda_oe_n = 1'b0;
        endcase
        if (load_rd) begin
            shreg_n  = rd_data;
            sda_oe_n = ~rd_data[7];
            ptr_n    = ptr_inc;
            state_n  = RDATA;
        end
        if (start_c) begin
            state_n  = ADDR;
            bcnt_n   = '0;
            sda_oe_n = 1'b0;
            wr_req_n = 1'b0;
        end
        if (stop_c) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            done_n   = busy;
            busy_n   = 1'b0;
            wr_req_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcnt    <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
            mack    <= 1'b0;
            wr_req  <= 1'b0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_n;
            bcnt    <= bcnt_n;
            shreg   <= shreg_n;
            rw      <= rw_n;
            mack    <= mack_n;
            wr_req  <= wr_req_n;
            ptr     <= ptr_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            done    <= done_n;
            ack_err <= ack_err_n;
        end
    end

    // Register file: identity contents on reset, registered read of the current pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'(i);
            rd_data <= '0;
        end else begin
            if (wr_req) mem[ptr[AW-1:0]] <= shreg;
            rd_data <= mem[ptr[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus-functional controller, transaction-level model, queue scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
    localparam int unsigned DEPTH = 128;
    localparam logic [6:0]  DEV   = 7'h50;
    localparam int          Q     = 80;

    logic       clk = 1'b0, rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1, scl_gl = 1'b0, glitch_en = 1'b0;
    logic       scl_pin, sda_line;
    logic       sda_oe, busy, done, ack_err;
    logic [7:0] ptr;

    assign sda_line = sda_m & ~sda_oe;
    assign scl_pin  = scl_m ^ scl_gl;

    always #5 clk = ~clk;

    i2c_target_regfile #(.DEV_ADDR(DEV), .MEM_DEPTH(DEPTH), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl(scl_pin), .sda_i(sda_line),
        .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err), .ptr(ptr)
    );

    typedef enum logic [1:0] {OBS_ACK, OBS_RD, OBS_DONE, OBS_ERR} kind_t;
    typedef struct packed { kind_t kind; logic [7:0] val; } obs_t;

    obs_t       obs_q[$];
    logic [7:0] exp_ack[$], exp_rd[$], exp_done[$], exp_err[$];
    int         errors = 0, checks = 0;
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_ptr;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, required nothing", name, act);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i);
        model_ptr = 8'h00;
    endtask

    // Observers: one-clk pulses are sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (done)    obs_q.push_back('{kind: OBS_DONE, val: 8'h01});
        if (ack_err) obs_q.push_back('{kind: OBS_ERR,  val: 8'h01});
    end

    initial begin : monitor
        obs_t o;
        forever begin
            @(negedge clk);
            while (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                case (o.kind)
                    OBS_ACK:  if (exp_ack.size() == 0) unexpected("ack_bit", o.val);
                              else check("ack_bit", o.val, exp_ack.pop_front());
                    OBS_RD:   if (exp_rd.size() == 0) unexpected("read_byte", o.val);
                              else check("read_byte", o.val, exp_rd.pop_front());
                    OBS_DONE: if (exp_done.size() == 0) unexpected("done_pulse", o.val);
                              else check("done_pulse", o.val, exp_done.pop_front());
                    default:  if (exp_err.size() == 0) unexpected("ack_err_pulse", o.val);
                              else check("ack_err_pulse", o.val, exp_err.pop_front());
                endcase
            end
        end
    end

    task automatic glitch();
        @(posedge clk);
        #2 scl_gl = 1'b1;
        #10 scl_gl = 1'b0;
    endtask

    // One SCL period: drive b while SCL is low, return the line level sampled while high
    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        #Q scl_m = 1'b1;
        #(Q/2) s = sda_line;
        if (glitch_en) glitch();
        #(Q/2) scl_m = 1'b0;
        #(Q/2);
        if (glitch_en) glitch();
        #(Q/2);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        obs_q.push_back('{kind: OBS_ACK, val: {7'd0, s}});
    endtask

    task automatic read_byte(input logic mack);
        logic       s;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        obs_q.push_back('{kind: OBS_RD, val: d});
        bit_cycle(mack, s);
    endtask

    task automatic tx_write(input logic [7:0] p, input int n, input logic [31:0] data);
        logic [7:0] b;
        bus_start();
        exp_ack.push_back(8'h00);
        write_byte({DEV, 1'b0});
        check("busy_after_match", {7'd0, busy}, 8'h01);
        if (p < DEPTH) begin
            exp_ack.push_back(8'h00);
            write_byte(p);
            model_ptr = p;
            for (int i = 0; i < n; i++) begin
                b = data[8*i +: 8];
                exp_ack.push_back(8'h00);
                write_byte(b);
                model_mem[model_ptr] = b;
                model_ptr = 8'((model_ptr + 1) % DEPTH);
            end
        end else begin
            exp_err.push_back(8'h01);
            exp_ack.push_back(8'h01);
            write_byte(p);
        end
        exp_done.push_back(8'h01);
        bus_stop();
        check("busy_after_stop", {7'd0, busy}, 8'h00);
        check("ptr_after_write", ptr, model_ptr);
    endtask

    task automatic tx_read(input int n, input logic set_ptr, input logic [7:0] p);
        bus_start();
        if (set_ptr) begin
            exp_ack.push_back(8'h00);
            write_byte({DEV, 1'b0});
            exp_ack.push_back(8'h00);
            write_byte(p);
            model_ptr = p;
            bus_start();
        end
        exp_ack.push_back(8'h00);
        write_byte({DEV, 1'b1});
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_mem[model_ptr]);
            model_ptr = 8'((model_ptr + 1) % DEPTH);
            read_byte(i == n - 1);
        end
        exp_done.push_back(8'h01);
        bus_stop();
        check("ptr_after_read", ptr, model_ptr);
    endtask

    task automatic tx_bad_addr(input logic [6:0] a);
        bus_start();
        exp_ack.push_back(8'h01);
        write_byte({a, 1'b0});
        check("busy_on_mismatch", {7'd0, busy}, 8'h00);
        bus_stop();
        check("ptr_on_mismatch", ptr, model_ptr);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic       s;
        logic [7:0] p;
        int         n;
        model_reset();
        repeat (10) @(posedge clk);
        #1;
        check("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_ptr", ptr, 8'h00);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        tx_read(4, 1'b0, 8'h00);
        tx_write(8'h10, 3, 32'h0033_2211);
        tx_read(3, 1'b1, 8'h10);
        tx_write(8'h7F, 2, 32'h0000_BBAA);
        tx_read(2, 1'b1, 8'h7F);
        tx_write(8'h80, 0, 32'h0);
        tx_read(1, 1'b1, 8'h00);
        tx_bad_addr(7'h51);
        tx_bad_addr(7'h00);

        glitch_en = 1'b1;
        tx_write(8'h40, 2, 32'h0000_C35A);
        glitch_en = 1'b0;
        tx_read(2, 1'b1, 8'h40);

        for (int it = 0; it < 5; it++) begin
            p = 8'($urandom_range(0, 135));
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) tx_write(p, n, $urandom);
            else                           tx_read(n, 1'b1, 8'(p % DEPTH));
        end

        // STOP in the middle of a data byte must not write it
        bus_start();
        exp_ack.push_back(8'h00);
        write_byte({DEV, 1'b0});
        exp_ack.push_back(8'h00);
        write_byte(8'h20);
        model_ptr = 8'h20;
        for (int i = 0; i < 4; i++) bit_cycle(~model_mem[8'h20][7-i], s);
        exp_done.push_back(8'h01);
        bus_stop();
        check("busy_after_partial", {7'd0, busy}, 8'h00);
        check("ptr_after_partial", ptr, model_ptr);
        tx_read(1, 1'b1, 8'h20);

        // Reset asserted part-way through a read
        bus_start();
        exp_ack.push_back(8'h00);
        write_byte({DEV, 1'b1});
        exp_rd.push_back(model_mem[model_ptr]);
        read_byte(1'b0);
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_ptr", ptr, 8'h00);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (10) @(posedge clk);
        tx_read(4, 1'b1, 8'h10);
        tx_read(1, 1'b1, 8'h7F);

        repeat (20) @(posedge clk);
        check("pending_ack", 8'(exp_ack.size()), 8'h00);
        check("pending_read", 8'(exp_rd.size()), 8'h00);
        check("pending_done", 8'(exp_done.size()), 8'h00);
        check("pending_ack_err", 8'(exp_err.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
